alu_8bit: RTL and testbench

- Registered 8-bit (parameterizable) combinational-core ALU with 16 operations selected by a 4-bit opcode.
- Result and carry/flag are captured on the clock edge, giving one-cycle latency.
- Leaf datapath block used by the RISC_V execute stage and directly by unit benches.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_comb.sv | 84 ++++++++
 rtl/alu_8bit.sv | 71 +++++++
 tb/tb_alu_8bit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the alu_8bit datapath block.
//   - ALU_SEL_W : width of the operation-select bus
//   - alu_op_e  : the 16 opcodes, encoded 0..15 in the order below
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_SEL_W = 4;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_DIV  = 4'd3,
        ALU_SHL  = 4'd4,
        ALU_SHR  = 4'd5,
        ALU_ROL  = 4'd6,
        ALU_ROR  = 4'd7,
        ALU_AND  = 4'd8,
        ALU_OR   = 4'd9,
        ALU_XOR  = 4'd10,
        ALU_NOR  = 4'd11,
        ALU_NAND = 4'd12,
        ALU_XNOR = 4'd13,
        ALU_GT   = 4'd14,
        ALU_EQ   = 4'd15
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// ---------------------------------------------------------------------------
// alu_comb
//   Pure combinational opcode decode and datapath for alu_8bit. Produces the
//   value the output registers will capture on the next clock edge.
//
//   Ports:
//     a, b        : WIDTH-bit unsigned operands
//     alu_sel     : operation select (alu_op_e encoding)
//     next_result : WIDTH-bit result of the selected operation
//     next_carry  : carry / borrow / shift-out / overflow flag
// ---------------------------------------------------------------------------
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [ALU_SEL_W-1:0] alu_sel,
    output logic [WIDTH-1:0]     next_result,
    output logic                 next_carry
);

    alu_op_e            op;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    assign op   = alu_op_e'(alu_sel);
    // Widen before the operation so the carry and the high product half survive.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        next_result = '0;
        next_carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                next_result = sum[WIDTH-1:0];
                next_carry  = sum[WIDTH];
            end
            ALU_SUB: begin
                next_result = a - b;
                next_carry  = (a < b);
            end
            ALU_MUL: begin
                next_result = prod[WIDTH-1:0];
                next_carry  = |prod[2*WIDTH-1:WIDTH];
            end
            ALU_DIV: begin
                // Divide-by-zero saturates and raises the flag instead of
                // leaving the divider output undefined.
                if (b == '0) begin
                    next_result = '1;
                    next_carry  = 1'b1;
                end else begin
                    next_result = a / b;
                end
            end
            ALU_SHL: begin
                next_result = {a[WIDTH-2:0], 1'b0};
                next_carry  = a[WIDTH-1];
            end
            ALU_SHR: begin
                next_result = {1'b0, a[WIDTH-1:1]};
                next_carry  = a[0];
            end
            ALU_ROL:  next_result = {a[WIDTH-2:0], a[WIDTH-1]};
            ALU_ROR:  next_result = {a[0], a[WIDTH-1:1]};
            ALU_AND:  next_result = a & b;
            ALU_OR:   next_result = a | b;
            ALU_XOR:  next_result = a ^ b;
            ALU_NOR:  next_result = ~(a | b);
            ALU_NAND: next_result = ~(a & b);
            ALU_XNOR: next_result = ~(a ^ b);
            ALU_GT:   next_result = {{(WIDTH-1){1'b0}}, (a > b)};
            ALU_EQ:   next_result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: begin
                next_result = '0;
                next_carry  = 1'b0;
            end
        endcase
    end

endmodule : alu_comb

// File: rtl/alu_8bit.sv
// ---------------------------------------------------------------------------
// alu_8bit
//   Registered ALU: 16 operations on two WIDTH-bit unsigned operands, with
//   the result and flag captured on each rising clock (one-cycle latency).
//   There is no valid/ready handshake: a new operation is taken every cycle
//   and the outputs always reflect the inputs sampled one edge earlier.
//
//   Ports:
//     clk        : rising-edge clock
//     rst_n      : asynchronous active-low reset, clears all outputs
//     a, b       : WIDTH-bit unsigned operands
//     alu_sel    : operation select (alu_pkg::alu_op_e encoding)
//     alu_result : registered result
//     carryout   : registered carry / borrow / shift-out flag
//     zero       : registered "result is all zeros" flag
//                  (present only when ALU_ZERO_FLAG_EN is defined)
//
//   Build option: define ALU_ZERO_FLAG_EN to add the zero output.
// ---------------------------------------------------------------------------
module alu_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [ALU_SEL_W-1:0] alu_sel,
    output logic [WIDTH-1:0]     alu_result,
`ifdef ALU_ZERO_FLAG_EN
    output logic                 zero,
`endif
    output logic                 carryout
);

    logic [WIDTH-1:0] next_result;
    logic             next_carry;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .a           (a),
        .b           (b),
        .alu_sel     (alu_sel),
        .next_result (next_result),
        .next_carry  (next_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
            carryout   <= 1'b0;
        end else begin
            alu_result <= next_result;
            carryout   <= next_carry;
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    // Derived from the pre-register value so it lines up with alu_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
        end else begin
            zero <= (next_result == '0);
        end
    end
`endif

endmodule : alu_8bit

// File: tb/tb_alu_8bit.sv
// ---------------------------------------------------------------------------
// tb_alu_8bit
//   Directed bench for alu_8bit (WIDTH=8): reset behaviour, an opcode sweep,
//   mixed-operand and boundary vectors, an asynchronous mid-stream reset and
//   a back-to-back sequence. Define ALU_ZERO_FLAG_EN to also check zero.
// ---------------------------------------------------------------------------
module tb_alu_8bit;
    import alu_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_sel;
    logic [W-1:0] alu_result;
    logic         carryout;
`ifdef ALU_ZERO_FLAG_EN
    logic         zero;
`endif

    always #5 clk = ~clk;

    alu_8bit #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
`ifdef ALU_ZERO_FLAG_EN
        .zero       (zero),
`endif
        .carryout   (carryout)
    );

    // ---------------- vector table ----------------
    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   sel;
        logic [W-1:0] res;
        logic         c;
    } vec_t;

    vec_t vecs[$];
    logic [W:0] exp_q[$];   // {carry, result} scoreboard

    int checks = 0;
    int errors = 0;

    task automatic add_vec(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [3:0] sel, input logic [W-1:0] res, input logic c);
        vec_t v;
        v.name = name; v.a = va; v.b = vb; v.sel = sel; v.res = res; v.c = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got carry/result %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name, input logic exp_z);
`ifdef ALU_ZERO_FLAG_EN
        checks++;
        if (zero !== exp_z) begin
            errors++;
            $display("FAIL %s zero: got %b, expected %b", name, zero, exp_z);
        end
`else
        if (exp_z === 1'bx) $display("unexpected x in %s", name);
`endif
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [3:0] sel);
        @(negedge clk);
        a = va;
        b = vb;
        alu_sel = sel;
    endtask

    task automatic sample_after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0;
        b = '0;
        alu_sel = '0;

        // Operand sweep 0x0A / 0x02 across all opcodes.
        add_vec("sweep_add",  8'h0A, 8'h02, 4'd0,  8'd12,  1'b0);
        add_vec("sweep_sub",  8'h0A, 8'h02, 4'd1,  8'd8,   1'b0);
        add_vec("sweep_mul",  8'h0A, 8'h02, 4'd2,  8'd20,  1'b0);
        add_vec("sweep_div",  8'h0A, 8'h02, 4'd3,  8'd5,   1'b0);
        add_vec("sweep_shl",  8'h0A, 8'h02, 4'd4,  8'd20,  1'b0);
        add_vec("sweep_shr",  8'h0A, 8'h02, 4'd5,  8'd5,   1'b0);
        add_vec("sweep_rol",  8'h0A, 8'h02, 4'd6,  8'd20,  1'b0);
        add_vec("sweep_ror",  8'h0A, 8'h02, 4'd7,  8'd5,   1'b0);
        add_vec("sweep_and",  8'h0A, 8'h02, 4'd8,  8'd2,   1'b0);
        add_vec("sweep_or",   8'h0A, 8'h02, 4'd9,  8'd10,  1'b0);
        add_vec("sweep_xor",  8'h0A, 8'h02, 4'd10, 8'd8,   1'b0);
        add_vec("sweep_nor",  8'h0A, 8'h02, 4'd11, 8'd245, 1'b0);
        add_vec("sweep_nand", 8'h0A, 8'h02, 4'd12, 8'd253, 1'b0);
        add_vec("sweep_xnor", 8'h0A, 8'h02, 4'd13, 8'd247, 1'b0);
        add_vec("sweep_gt",   8'h0A, 8'h02, 4'd14, 8'd1,   1'b0);
        add_vec("sweep_eq",   8'h0A, 8'h02, 4'd15, 8'd0,   1'b0);
        // Mixed operands 0xF2 / 0xD3 (0xF2*0xD3 = 0xC776).
        add_vec("f2d3_add",   8'hF2, 8'hD3, 4'd0,  8'hC5,  1'b1);
        add_vec("f2d3_sub",   8'hF2, 8'hD3, 4'd1,  8'h1F,  1'b0);
        add_vec("f2d3_mul",   8'hF2, 8'hD3, 4'd2,  8'h76,  1'b1);
        add_vec("f2d3_shl",   8'hF2, 8'hD3, 4'd4,  8'hE4,  1'b1);
        add_vec("f2d3_ror",   8'hF2, 8'hD3, 4'd7,  8'h79,  1'b0);
        add_vec("f2d3_gt",    8'hF2, 8'hD3, 4'd14, 8'h01,  1'b0);
        // Boundaries.
        add_vec("div_by_0",   8'h37, 8'h00, 4'd3,  8'hFF,  1'b1);
        add_vec("sub_borrow", 8'h00, 8'h01, 4'd1,  8'hFF,  1'b1);
        add_vec("add_wrap",   8'hFF, 8'h01, 4'd0,  8'h00,  1'b1);
        add_vec("eq_same",    8'h5A, 8'h5A, 4'd15, 8'h01,  1'b0);
        add_vec("shr_out",    8'h81, 8'hFF, 4'd5,  8'h40,  1'b1);
        add_vec("xor_zero",   8'h33, 8'h33, 4'd10, 8'h00,  1'b0);
        add_vec("add_nz",     8'h0A, 8'h02, 4'd0,  8'h0C,  1'b0);

        // Reset state while rst_n is held low from time zero.
        #3;
        check("reset_init", {carryout, alu_result}, 9'h000);
        check_zero("reset_init", 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one vector per cycle, result checked one edge later.
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].sel);
            sample_after_edge();
            check(vecs[i].name, {carryout, alu_result}, {vecs[i].c, vecs[i].res});
            check_zero(vecs[i].name, (vecs[i].res == 8'h00));
        end

        // Asynchronous reset mid-stream, between clock edges.
        drive(8'hF2, 8'hD3, 4'd0);
        sample_after_edge();
        check("pre_reset", {carryout, alu_result}, 9'h1C5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {carryout, alu_result}, 9'h000);
        check_zero("async_reset", 1'b0);
        sample_after_edge();
        check("reset_hold_edge", {carryout, alu_result}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_released", {carryout, alu_result}, 9'h000);
        sample_after_edge();
        check("first_after_reset", {carryout, alu_result}, 9'h1C5);

        // Back-to-back: new op every cycle, scoreboard pops one per edge.
        begin
            logic [W-1:0] sa[8];
            logic [W-1:0] sb[8];
            logic [3:0]   ss[8];
            logic [W:0]   se[8];
            sa = '{8'h10, 8'h30, 8'hFF, 8'h81, 8'h81, 8'h10, 8'hFF, 8'h00};
            sb = '{8'h20, 8'h10, 8'h0F, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00};
            ss = '{4'd0,  4'd1,  4'd10, 4'd5,  4'd6,  4'd2,  4'd3,  4'd11};
            se = '{9'h030, 9'h020, 9'h0F0, 9'h140, 9'h003, 9'h100, 9'h00F, 9'h0FF};
            for (int i = 0; i < 8; i++) begin
                drive(sa[i], sb[i], ss[i]);
                exp_q.push_back(se[i]);
                sample_after_edge();
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_%0d: scoreboard empty", i);
                end else begin
                    check($sformatf("b2b_%0d", i), {carryout, alu_result}, exp_q.pop_front());
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_8bit
